ifu_bus_bridge: RTL and testbench
=================================

// Module: ifu_bus_bridge
// PURPOSE
//   Memory-side partner of the fetch unit: answers each one-cycle reqValid pulse
//   with exactly one one-cycle respValid pulse carrying the instruction word.
//   Translates each fetch into a single read on a valid/ready address (AR)
//   channel and data (R) channel towards the instruction bus/SRAM.
//   Checks alignment, maps bus errors to a NOP plus an error flag, and counts
//   fetch stall cycles for performance monitoring.
// PARAMETERS
//   ADDR_W   32            fetch/bus address width
//   DATA_W   32            instruction/bus data width
//   NOP_INST 32'h00000013  word returned on misaligned fetch or bus error
//   CNT_W    32            stall counter width
// PORTS
//   clock       in   1       sole clock; all state updates on posedge clock
//   reset       in   1       synchronous reset, active-high
//   reqValid    in   1       fetch request pulse from the fetch unit (1 cycle)
//   pc          in   ADDR_W  fetch address; sampled only when reqValid=1
//   respValid   out  1       registered 1-cycle pulse: inst/resp_err valid
//   inst        out  DATA_W  fetched instruction; held until the next respValid
//   resp_err    out  1       valid with respValid: 1 = misaligned or bus error
//   arvalid     out  1       bus read-address valid
//   arready     in   1       bus read-address ready
//   araddr      out  ADDR_W  bus read address (pc as captured)
//   rvalid      in   1       bus read-data valid
//   rready      out  1       bus read-data ready
//   rdata       in   DATA_W  bus read data
//   rresp       in   2       bus response; 2'b00 = OK, anything else = error
//   stall_cnt   out  CNT_W   cycles spent in ADDR/DATA since reset; saturates
// BEHAVIOUR
//   Reset (sync, on clock edge with reset=1): state=IDLE; respValid=0,
//     resp_err=0, inst=NOP_INST, arvalid=0, rready=0, araddr=0, stall_cnt=0.
//     Reset mid-transaction abandons it; a late rvalid is then ignored (rready=0).
//   States: IDLE, ADDR, DATA, RESP.
//   IDLE: reqValid=1 and pc[1:0]==0 -> capture araddr<=pc, go ADDR.
//         reqValid=1 and pc[1:0]!=0 -> no bus access; inst<=NOP_INST,
//         resp_err<=1, go RESP.
//   ADDR: arvalid=1, araddr stable. arvalid is never dropped before arready.
//         arready=1 -> go DATA. Otherwise stay.
//   DATA: rready=1. rvalid=1 -> inst<=(rresp==0 ? rdata : NOP_INST),
//         resp_err<=(rresp!=0), go RESP. Otherwise stay.
//   RESP: respValid=1 for exactly this cycle; go IDLE unconditionally.
//   arvalid/rready/respValid are decoded from registered state only (no
//     combinational path from any input to any output).
//   Latency, zero-wait bus (arready=1, rvalid one cycle after AR handshake):
//     reqValid @T -> arvalid @T+1 -> rvalid @T+2 -> respValid @T+3.
//     Misaligned: reqValid @T -> respValid @T+1. Each bus wait cycle adds 1.
//   reqValid while state!=IDLE is a protocol violation: ignored, no second
//     transaction, no second respValid. reqValid in RESP is likewise ignored.
//   inst/resp_err update only on DATA completion or misaligned capture; stable
//     otherwise.
//   stall_cnt: +1 each cycle state is ADDR or DATA; saturates at 2^CNT_W-1.
// TESTING
//   1. Zero-wait: reqValid @T, pc=0x80000004, arready=1, rdata=0x00500093
//      @T+2 rresp=0 -> araddr=0x80000004 @T+1; respValid @T+3 only;
//      inst=0x00500093, resp_err=0; stall_cnt=2.
//   2. Backpressure: arready low 3 cycles, rvalid 2 cycles after handshake ->
//      arvalid/araddr stable throughout; respValid @T+7; stall_cnt=6.
//   3. Misaligned pc=0x80000002 -> arvalid never asserts; respValid @T+1,
//      inst=0x00000013, resp_err=1; stall_cnt unchanged.
//   4. Bus error rresp=2'b10, rdata=0xDEADBEEF -> inst=0x00000013, resp_err=1,
//      exactly one respValid; next good fetch returns clean data, resp_err=0.
//   5. Spurious reqValid during DATA and during RESP -> single AR handshake,
//      single respValid; state IDLE afterwards.
//   6. Reset asserted in DATA, rvalid=1 next cycle -> outputs at reset values,
//      rready=0, no respValid; a fresh fetch then completes normally.

Source files
------------

// File: rtl/ifu_bus_bridge.sv
// Fetch-side bus bridge: turns each fetch request pulse into one AR/R read and
// returns exactly one response pulse with the instruction (or NOP on error).
module ifu_bus_bridge #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [DATA_W-1:0]    NOP_INST = DATA_W'(32'h00000013),
    parameter int unsigned          CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic [ADDR_W-1:0] pc,
    output logic              respValid,
    output logic [DATA_W-1:0] inst,
    output logic              resp_err,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;

    // Handshake outputs are registered together with the state so no input
    // reaches an output combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            respValid <= 1'b0;
            resp_err  <= 1'b0;
            inst      <= NOP_INST;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            araddr    <= '0;
            stall_cnt <= '0;
        end else begin
            respValid <= 1'b0;

            if ((state == ADDR || state == DATA) && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (reqValid) begin
                        if (pc[1:0] == 2'b00) begin
                            araddr  <= pc;
                            arvalid <= 1'b1;
                            state   <= ADDR;
                        end else begin
                            inst      <= NOP_INST;
                            resp_err  <= 1'b1;
                            respValid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        inst      <= (rresp == 2'b00) ? rdata : NOP_INST;
                        resp_err  <= (rresp != 2'b00);
                        respValid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_bus_bridge.sv
// Directed bench for ifu_bus_bridge: latency, backpressure, misalignment,
// bus errors, spurious requests, mid-transaction reset and counter saturation.
module tb_ifu_bus_bridge;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic [31:0] pc = '0;
    logic        respValid;
    logic [31:0] inst;
    logic        resp_err;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic [31:0] stall_cnt;

    logic        sat_respValid;
    logic [31:0] sat_inst;
    logic        sat_resp_err;
    logic        sat_arvalid;
    logic [31:0] sat_araddr;
    logic        sat_rready;
    logic [2:0]  sat_stall_cnt;

    int nchk = 0;
    int nbad = 0;
    int resp_seen = 0;
    int ar_seen = 0;
    logic [31:0] exp_stall = '0;

    always #5 clock = ~clock;

    ifu_bus_bridge u_dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .pc(pc),
        .respValid(respValid), .inst(inst), .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter instance sharing the same stimulus, to exercise saturation.
    ifu_bus_bridge #(.CNT_W(3)) u_sat (
        .clock(clock), .reset(reset), .reqValid(reqValid), .pc(pc),
        .respValid(sat_respValid), .inst(sat_inst), .resp_err(sat_resp_err),
        .arvalid(sat_arvalid), .arready(arready), .araddr(sat_araddr),
        .rvalid(rvalid), .rready(sat_rready), .rdata(rdata), .rresp(rresp),
        .stall_cnt(sat_stall_cnt)
    );

    always @(posedge clock) begin
        if (respValid) resp_seen++;
        if (arvalid && arready) ar_seen++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        nchk++; if (respValid !== 1'b0) begin nbad++; $display("FAIL reset_respValid got=%h exp=0", respValid); end
        nchk++; if (resp_err !== 1'b0) begin nbad++; $display("FAIL reset_resp_err got=%h exp=0", resp_err); end
        nchk++; if (inst !== NOP) begin nbad++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
        nchk++; if (arvalid !== 1'b0 || rready !== 1'b0) begin nbad++; $display("FAIL reset_handshake got=%b%b exp=00", arvalid, rready); end
        nchk++; if (araddr !== 32'h0) begin nbad++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
        nchk++; if (stall_cnt !== 32'h0) begin nbad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        reset = 1'b0;
        exp_stall = '0;
        tick();
    endtask

    task automatic test_zero_wait();
        int r0;
        r0 = resp_seen;
        arready = 1'b1;
        reqValid = 1'b1; pc = 32'h80000004;
        tick();
        reqValid = 1'b0;
        nchk++; if (arvalid !== 1'b1 || araddr !== 32'h80000004) begin nbad++; $display("FAIL zw_ar got=%b/%h exp=1/80000004", arvalid, araddr); end
        nchk++; if (respValid !== 1'b0) begin nbad++; $display("FAIL zw_early_resp1 got=%b exp=0", respValid); end
        tick();
        nchk++; if (arvalid !== 1'b0 || rready !== 1'b1 || respValid !== 1'b0) begin nbad++; $display("FAIL zw_data got=ar%b r%b v%b exp=ar0 r1 v0", arvalid, rready, respValid); end
        rvalid = 1'b1; rdata = 32'h00500093; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        exp_stall += 2;
        nchk++; if (respValid !== 1'b1) begin nbad++; $display("FAIL zw_resp got=%b exp=1", respValid); end
        nchk++; if (inst !== 32'h00500093 || resp_err !== 1'b0) begin nbad++; $display("FAIL zw_inst got=%h/%b exp=00500093/0", inst, resp_err); end
        nchk++; if (stall_cnt !== exp_stall) begin nbad++; $display("FAIL zw_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        nchk++; if (sat_stall_cnt !== 3'd2) begin nbad++; $display("FAIL zw_sat_stall got=%0d exp=2", sat_stall_cnt); end
        tick();
        nchk++; if (respValid !== 1'b0 || resp_seen - r0 != 1) begin nbad++; $display("FAIL zw_single got=%b/%0d exp=0/1", respValid, resp_seen - r0); end
    endtask

    task automatic test_backpressure();
        int r0;
        int a0;
        r0 = resp_seen; a0 = ar_seen;
        arready = 1'b0;
        reqValid = 1'b1; pc = 32'h00001000;
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nchk++; if (arvalid !== 1'b1 || araddr !== 32'h00001000) begin nbad++; $display("FAIL bp_ar_stable%0d got=%b/%h exp=1/00001000", i, arvalid, araddr); end
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        nchk++; if (arvalid !== 1'b0 || rready !== 1'b1) begin nbad++; $display("FAIL bp_data got=ar%b r%b exp=ar0 r1", arvalid, rready); end
        rdata = 32'h12345678;
        tick();
        nchk++; if (respValid !== 1'b0 || rready !== 1'b1) begin nbad++; $display("FAIL bp_wait got=v%b r%b exp=v0 r1", respValid, rready); end
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        exp_stall += 6;
        nchk++; if (respValid !== 1'b1 || inst !== 32'h12345678 || resp_err !== 1'b0) begin nbad++; $display("FAIL bp_resp got=%b/%h/%b exp=1/12345678/0", respValid, inst, resp_err); end
        nchk++; if (stall_cnt !== exp_stall) begin nbad++; $display("FAIL bp_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        nchk++; if (sat_stall_cnt !== 3'd7) begin nbad++; $display("FAIL bp_sat_stall got=%0d exp=7", sat_stall_cnt); end
        tick();
        nchk++; if (resp_seen - r0 != 1 || ar_seen - a0 != 1) begin nbad++; $display("FAIL bp_counts got=%0d/%0d exp=1/1", resp_seen - r0, ar_seen - a0); end
    endtask

    task automatic test_misaligned();
        arready = 1'b1;
        reqValid = 1'b1; pc = 32'h80000002;
        tick();
        reqValid = 1'b0;
        nchk++; if (respValid !== 1'b1 || arvalid !== 1'b0) begin nbad++; $display("FAIL mis_resp got=v%b ar%b exp=v1 ar0", respValid, arvalid); end
        nchk++; if (inst !== NOP || resp_err !== 1'b1) begin nbad++; $display("FAIL mis_inst got=%h/%b exp=%h/1", inst, resp_err, NOP); end
        tick();
        nchk++; if (respValid !== 1'b0 || arvalid !== 1'b0) begin nbad++; $display("FAIL mis_after got=v%b ar%b exp=v0 ar0", respValid, arvalid); end
        nchk++; if (stall_cnt !== exp_stall) begin nbad++; $display("FAIL mis_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_bus_error();
        int r0;
        r0 = resp_seen;
        arready = 1'b1;
        reqValid = 1'b1; pc = 32'h00000040;
        tick();
        reqValid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        nchk++; if (respValid !== 1'b1 || inst !== NOP || resp_err !== 1'b1) begin nbad++; $display("FAIL berr_resp got=%b/%h/%b exp=1/%h/1", respValid, inst, resp_err, NOP); end
        tick();
        tick();
        nchk++; if (resp_seen - r0 != 1 || inst !== NOP || resp_err !== 1'b1) begin nbad++; $display("FAIL berr_hold got=%0d/%h/%b exp=1/%h/1", resp_seen - r0, inst, resp_err, NOP); end
        reqValid = 1'b1; pc = 32'h00000044;
        tick();
        reqValid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h00A00113;
        tick();
        rvalid = 1'b0;
        exp_stall += 4;
        nchk++; if (respValid !== 1'b1 || inst !== 32'h00A00113 || resp_err !== 1'b0) begin nbad++; $display("FAIL berr_recover got=%b/%h/%b exp=1/00a00113/0", respValid, inst, resp_err); end
        tick();
    endtask

    task automatic test_spurious();
        int r0;
        int a0;
        r0 = resp_seen; a0 = ar_seen;
        arready = 1'b1;
        reqValid = 1'b1; pc = 32'h00000100;
        tick();
        reqValid = 1'b0;
        tick();
        reqValid = 1'b1; pc = 32'h00000200;
        rvalid = 1'b1; rdata = 32'h11111111;
        tick();
        rvalid = 1'b0;
        pc = 32'h00000300;
        nchk++; if (respValid !== 1'b1 || inst !== 32'h11111111) begin nbad++; $display("FAIL sp_resp got=%b/%h exp=1/11111111", respValid, inst); end
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nchk++; if (respValid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin nbad++; $display("FAIL sp_idle%0d got=v%b ar%b r%b exp=000", i, respValid, arvalid, rready); end
            tick();
        end
        exp_stall += 2;
        nchk++; if (resp_seen - r0 != 1 || ar_seen - a0 != 1) begin nbad++; $display("FAIL sp_counts got=%0d/%0d exp=1/1", resp_seen - r0, ar_seen - a0); end
        nchk++; if (araddr !== 32'h00000100 || stall_cnt !== exp_stall) begin nbad++; $display("FAIL sp_state got=%h/%0d exp=00000100/%0d", araddr, stall_cnt, exp_stall); end
    endtask

    task automatic test_reset_mid();
        int r0;
        arready = 1'b1;
        reqValid = 1'b1; pc = 32'h00000400;
        tick();
        reqValid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r0 = resp_seen;
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        exp_stall = '0;
        nchk++; if (rready !== 1'b0 || arvalid !== 1'b0 || respValid !== 1'b0) begin nbad++; $display("FAIL rm_outs got=r%b ar%b v%b exp=000", rready, arvalid, respValid); end
        nchk++; if (inst !== NOP || resp_err !== 1'b0 || araddr !== 32'h0 || stall_cnt !== 32'h0) begin nbad++; $display("FAIL rm_regs got=%h/%b/%h/%0d exp=%h/0/0/0", inst, resp_err, araddr, stall_cnt, NOP); end
        tick();
        rvalid = 1'b0;
        tick();
        nchk++; if (resp_seen != r0 || inst !== NOP) begin nbad++; $display("FAIL rm_ignored got=%0d/%h exp=0/%h", resp_seen - r0, inst, NOP); end
        reqValid = 1'b1; pc = 32'h00000408;
        tick();
        reqValid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h0000A0B3;
        tick();
        rvalid = 1'b0;
        exp_stall += 2;
        nchk++; if (respValid !== 1'b1 || inst !== 32'h0000A0B3 || resp_err !== 1'b0 || stall_cnt !== exp_stall) begin nbad++; $display("FAIL rm_fresh got=%b/%h/%b/%0d exp=1/0000a0b3/0/%0d", respValid, inst, resp_err, stall_cnt, exp_stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_misaligned();
        test_bus_error();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
